ysyx_23060025_ifu: RTL and testbench

YSYX_23060025_IFU -- requirements
Module: ysyx_23060025_IFU

---
 rtl/ysyx_23060025_pkg.sv | 15 +
 rtl/ysyx_23060025_ifu_pc.sv | 34 +++
 rtl/ysyx_23060025_ifu.sv | 122 ++++++++++++
 tb/tb_ysyx_23060025_ifu.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060025_pkg.sv
// Shared definitions for the ysyx_23060025 instruction fetch unit:
// FSM state encoding, AXI-lite response codes and the default boot address.
package ysyx_23060025_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_OUT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060025_ifu_pc.sv
// Program counter: a redirect loads the word-aligned target and wins over
// a sequential advance; the increment wraps modulo 2^32.
module ysyx_23060025_ifu_pc
  import ysyx_23060025_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = redirect_pc & 32'hFFFF_FFFC;
    end else if (advance) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ysyx_23060025_ifu.sv
// Instruction fetch unit: issues one AXI-lite read at a time, hands the word
// to decode, and discards reads made stale by a jump/branch redirect.
module ysyx_23060025_ifu
  import ysyx_23060025_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic [1:0]  ifu_rresp,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  input  logic        idu_ready_i,
  output logic        fault_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output ifu_state_e  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a raised valid and its payload are held unchanged until that transfer.
  ifu_state_e  state, state_next;
  logic        drop, drop_next;
  logic        advance, capture, load_addr;
  logic [31:0] pc, pc_next;
  logic [31:0] araddr_q, inst_q, pc_q;
  logic        fault_q;

  ysyx_23060025_ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .advance     (advance),
    .pc          (pc),
    .pc_next     (pc_next)
  );

  always_comb begin
    state_next = state;
    drop_next  = drop;
    advance    = 1'b0;
    capture    = 1'b0;
    case (state)
      IFU_IDLE: state_next = IFU_REQ;
      IFU_REQ: begin
        if (redirect_i) drop_next = 1'b1;
        if (ifu_arready) state_next = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (ifu_rvalid) begin
          // A stale or simultaneously redirected response is consumed and thrown away.
          drop_next  = 1'b0;
          state_next = IFU_REQ;
          if (!drop && !redirect_i) begin
            state_next = IFU_OUT;
            capture    = 1'b1;
          end
        end else if (redirect_i) begin
          drop_next = 1'b1;
        end
      end
      IFU_OUT: begin
        if (redirect_i) begin
          state_next = IFU_REQ;
        end else if (idu_ready_i) begin
          state_next = IFU_REQ;
          advance    = 1'b1;
        end
      end
      default: state_next = IFU_IDLE;
    endcase
  end

  // The read address is latched on entry to REQ so it cannot move while arvalid is up.
  assign load_addr = (state_next == IFU_REQ) && (state != IFU_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IFU_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q <= RESET_PC;
      inst_q   <= 32'd0;
      pc_q     <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      if (load_addr) araddr_q <= pc_next;
      if (capture) begin
        inst_q  <= ifu_rdata;
        pc_q    <= pc;
        fault_q <= (ifu_rresp != RESP_OKAY);
      end
    end
  end

  assign ifu_araddr   = araddr_q;
  assign ifu_arvalid  = (state == IFU_REQ);
  assign ifu_rready   = (state == IFU_WAIT);
  assign inst_valid_o = (state == IFU_OUT);
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign fault_o      = fault_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_ysyx_23060025_ifu.sv
// Self-checking bench for ysyx_23060025_ifu: AXI-lite read slave model,
// directed scenarios and a randomized run against an architectural PC model.
module tb_ysyx_23060025_ifu;
  import ysyx_23060025_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready = 1'b0;
  logic [31:0] ifu_rdata = 32'd0;
  logic [1:0]  ifu_rresp = 2'b00;
  logic        ifu_rvalid = 1'b0;
  logic        ifu_rready;
  logic [31:0] inst_o, pc_o;
  logic        inst_valid_o, fault_o;
  logic        idu_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  ifu_state_e  dbg_state;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  // slave configuration
  int          r_min = 0, r_max = 0;
  bit          ar_random = 0, fault_pat = 0, ovr_en = 0;
  logic [31:0] ovr_data = 32'd0;
  logic [1:0]  ovr_resp = 2'b00;

  always #5 clk = ~clk;

  ysyx_23060025_ifu #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_araddr    (ifu_araddr),
    .ifu_arvalid   (ifu_arvalid),
    .ifu_arready   (ifu_arready),
    .ifu_rdata     (ifu_rdata),
    .ifu_rresp     (ifu_rresp),
    .ifu_rvalid    (ifu_rvalid),
    .ifu_rready    (ifu_rready),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .inst_valid_o  (inst_valid_o),
    .idu_ready_i   (idu_ready_i),
    .fault_o       (fault_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .dbg_state     (dbg_state)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (fault_pat && a[4:2] == 3'd5) ? 2'b10 : 2'b00;
  endfunction

  // Memory slave: handshakes observed mid-cycle, new inputs driven just after the edge.
  bit          s_hs_ar, s_hs_r, outstanding = 0;
  logic [31:0] s_addr, out_addr = 32'd0;
  int          r_cnt = 0;
  always begin
    @(negedge clk);
    s_hs_ar = ifu_arvalid && ifu_arready;
    s_hs_r  = ifu_rvalid && ifu_rready;
    s_addr  = ifu_araddr;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (s_hs_r) outstanding = 0;
      if (s_hs_ar) begin
        outstanding = 1;
        out_addr    = s_addr;
        r_cnt       = $urandom_range(r_max, r_min);
      end else if (outstanding && r_cnt > 0) begin
        r_cnt--;
      end
    end
    ifu_arready = ar_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    ifu_rvalid  = outstanding && (r_cnt == 0);
    ifu_rdata   = ovr_en ? ovr_data : word_of(out_addr);
    ifu_rresp   = ovr_en ? ovr_resp : resp_of(out_addr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // sel: 0 = inst_valid_o, 1 = ifu_arvalid, 2 = ifu_rready
  task automatic wait_for(input int sel, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if ((sel == 0 && inst_valid_o) || (sel == 1 && ifu_arvalid) || (sel == 2 && ifu_rready)) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    tests += 8;
    if (ifu_araddr !== RST_PC) begin fails++; $display("FAIL reset_araddr: got %h exp %h", ifu_araddr, RST_PC); end
    if (ifu_arvalid !== 1'b0) begin fails++; $display("FAIL reset_arvalid: got %b exp 0", ifu_arvalid); end
    if (ifu_rready !== 1'b0) begin fails++; $display("FAIL reset_rready: got %b exp 0", ifu_rready); end
    if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b exp 0", inst_valid_o); end
    if (fault_o !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b exp 0", fault_o); end
    if (inst_o !== 32'd0) begin fails++; $display("FAIL reset_inst: got %h exp 0", inst_o); end
    if (pc_o !== 32'd0) begin fails++; $display("FAIL reset_pc_o: got %h exp 0", pc_o); end
    if (dbg_state !== IFU_IDLE) begin fails++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IFU_IDLE); end
  endtask

  task automatic test_stream();
    int n_ar = 0, n_v = 0, last_v = -1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) exp_q.push_back(RST_PC + 32'(4 * k));
    idu_ready_i = 1'b1;
    for (int c = 0; c < 40 && n_v < 3; c++) begin
      if (ifu_arvalid && ifu_arready && n_ar < 3) begin
        tests++;
        if (ifu_araddr !== exp_q[n_ar]) begin fails++; $display("FAIL stream_araddr: got %h exp %h", ifu_araddr, exp_q[n_ar]); end
        n_ar++;
      end
      if (inst_valid_o) begin
        tests += 2;
        if (pc_o !== exp_q[n_v]) begin fails++; $display("FAIL stream_pc: got %h exp %h", pc_o, exp_q[n_v]); end
        if (inst_o !== word_of(exp_q[n_v])) begin fails++; $display("FAIL stream_inst: got %h exp %h", inst_o, word_of(exp_q[n_v])); end
        if (last_v >= 0) begin
          tests++;
          if (c - last_v != 3) begin fails++; $display("FAIL stream_spacing: got %0d exp 3", c - last_v); end
        end
        last_v = c;
        n_v++;
      end
      tick();
    end
    tests++;
    if (n_v != 3) begin fails++; $display("FAIL stream_timeout: got %0d instructions exp 3", n_v); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] cap_inst, cap_pc;
    idu_ready_i = 1'b0;
    wait_for(0, 20, ok);
    tests += 2;
    if (!ok) begin fails++; $display("FAIL stall_timeout: got no inst_valid exp 1"); end
    if (pc_o !== 32'h8000_000C) begin fails++; $display("FAIL stall_pc: got %h exp 8000000c", pc_o); end
    cap_inst = inst_o;
    cap_pc   = pc_o;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests += 4;
      if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL stall_valid: got %b exp 1", inst_valid_o); end
      if (inst_o !== cap_inst) begin fails++; $display("FAIL stall_inst: got %h exp %h", inst_o, cap_inst); end
      if (pc_o !== cap_pc) begin fails++; $display("FAIL stall_pc_hold: got %h exp %h", pc_o, cap_pc); end
      if (ifu_arvalid !== 1'b0) begin fails++; $display("FAIL stall_arvalid: got %b exp 0", ifu_arvalid); end
    end
    idu_ready_i = 1'b1;
    tick();
    wait_for(1, 20, ok);
    tests++;
    if (!ok || ifu_araddr !== cap_pc + 32'd4) begin fails++; $display("FAIL stall_next_araddr: got %h exp %h", ifu_araddr, cap_pc + 32'd4); end
  endtask

  task automatic test_redirect_wait();
    bit ok, seen_ar = 0, seen_v = 0;
    r_min = 3; r_max = 3;
    idu_ready_i = 1'b1;
    wait_for(2, 20, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rdw_timeout: got no rready exp 1"); end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0102;
    tick();
    redirect_i = 1'b0;
    for (int c = 0; c < 40 && !seen_v; c++) begin
      if (ifu_arvalid && ifu_arready && !seen_ar) begin
        tests++;
        seen_ar = 1;
        if (ifu_araddr !== 32'h8000_0100) begin fails++; $display("FAIL rdw_araddr: got %h exp 80000100", ifu_araddr); end
      end
      if (inst_valid_o) begin
        tests += 2;
        seen_v = 1;
        if (pc_o !== 32'h8000_0100) begin fails++; $display("FAIL rdw_pc: got %h exp 80000100", pc_o); end
        if (inst_o !== word_of(32'h8000_0100)) begin fails++; $display("FAIL rdw_inst: got %h exp %h", inst_o, word_of(32'h8000_0100)); end
      end else begin
        tick();
      end
    end
    tests++;
    if (!seen_v) begin fails++; $display("FAIL rdw_no_delivery: got 0 exp 1"); end
    r_min = 0; r_max = 0;
  endtask

  task automatic test_redirect_out();
    bit ok;
    idu_ready_i = 1'b0;
    wait_for(0, 20, ok);
    idu_ready_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h8000_0200;
    tick();
    redirect_i = 1'b0;
    tests += 2;
    if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL rdo_valid_clear: got %b exp 0", inst_valid_o); end
    wait_for(1, 20, ok);
    if (!ok || ifu_araddr !== 32'h8000_0200) begin fails++; $display("FAIL rdo_araddr: got %h exp 80000200", ifu_araddr); end
  endtask

  task automatic test_fault();
    bit ok;
    idu_ready_i = 1'b0;
    wait_for(0, 20, ok);
    ovr_en = 1; ovr_data = 32'h0000_0013; ovr_resp = 2'b10;
    idu_ready_i = 1'b1;
    tick();
    idu_ready_i = 1'b0;
    wait_for(0, 20, ok);
    for (int i = 0; i < 3; i++) begin
      tests += 3;
      if (inst_valid_o !== 1'b1) begin fails++; $display("FAIL fault_valid: got %b exp 1", inst_valid_o); end
      if (fault_o !== 1'b1) begin fails++; $display("FAIL fault_flag: got %b exp 1", fault_o); end
      if (inst_o !== 32'h0000_0013) begin fails++; $display("FAIL fault_inst: got %h exp 00000013", inst_o); end
      tick();
    end
    ovr_en = 0;
    idu_ready_i = 1'b1;
    tick();
    wait_for(0, 20, ok);
    tests++;
    if (!ok || fault_o !== 1'b0) begin fails++; $display("FAIL fault_clear: got %b exp 0", fault_o); end
  endtask

  task automatic test_async_reset();
    bit ok;
    r_min = 4; r_max = 4;
    idu_ready_i = 1'b1;
    wait_for(2, 20, ok);
    rst_n = 1'b0;
    #1;
    tests += 8;
    if (!ok) begin fails++; $display("FAIL arst_timeout: got no rready exp 1"); end
    if (ifu_araddr !== RST_PC) begin fails++; $display("FAIL arst_araddr: got %h exp %h", ifu_araddr, RST_PC); end
    if (ifu_arvalid !== 1'b0) begin fails++; $display("FAIL arst_arvalid: got %b exp 0", ifu_arvalid); end
    if (ifu_rready !== 1'b0) begin fails++; $display("FAIL arst_rready: got %b exp 0", ifu_rready); end
    if (inst_valid_o !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b exp 0", inst_valid_o); end
    if (fault_o !== 1'b0) begin fails++; $display("FAIL arst_fault: got %b exp 0", fault_o); end
    if (inst_o !== 32'd0) begin fails++; $display("FAIL arst_inst: got %h exp 0", inst_o); end
    if (pc_o !== 32'd0) begin fails++; $display("FAIL arst_pc_o: got %h exp 0", pc_o); end
    tick();
    tick();
    rst_n = 1'b1;
    r_min = 0; r_max = 0;
    wait_for(1, 20, ok);
    tests++;
    if (!ok || ifu_araddr !== RST_PC) begin fails++; $display("FAIL arst_first_araddr: got %h exp %h", ifu_araddr, RST_PC); end
  endtask

  task automatic test_random();
    logic [31:0] mpc = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] tgt;
    bit          prev_pending = 0;
    int          delivered = 0;
    r_min = 0; r_max = 3; ar_random = 1; fault_pat = 1;
    for (int i = 0; i < 600; i++) begin
      if (prev_pending) begin
        tests++;
        if (ifu_arvalid !== 1'b1 || ifu_araddr !== prev_addr) begin
          fails++; $display("FAIL rnd_ar_stable: got %b/%h exp 1/%h", ifu_arvalid, ifu_araddr, prev_addr);
        end
      end
      if (inst_valid_o) begin
        tests += 3;
        if (pc_o !== mpc) begin fails++; $display("FAIL rnd_pc: got %h exp %h", pc_o, mpc); end
        if (inst_o !== word_of(mpc)) begin fails++; $display("FAIL rnd_inst: got %h exp %h", inst_o, word_of(mpc)); end
        if (fault_o !== (resp_of(mpc) != 2'b00)) begin fails++; $display("FAIL rnd_fault: got %b exp %b", fault_o, resp_of(mpc) != 2'b00); end
      end
      idu_ready_i = ($urandom_range(0, 3) != 0);
      redirect_i  = (i == 0) || ($urandom_range(0, 24) == 0);
      tgt = (i == 0) ? 32'hFFFF_FFF3 :
            ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFE0 | ($urandom() & 32'h1F)) : $urandom();
      redirect_pc_i = tgt;
      if (redirect_i) begin
        mpc = {tgt[31:2], 2'b00};
      end else if (inst_valid_o && idu_ready_i) begin
        mpc = mpc + 32'd4;
        delivered++;
      end
      prev_pending = ifu_arvalid && !ifu_arready;
      prev_addr    = ifu_araddr;
      tick();
    end
    redirect_i = 1'b0;
    tests++;
    if (delivered < 30) begin fails++; $display("FAIL rnd_progress: got %0d exp >= 30", delivered); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_out();
    test_fault();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
